// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the multi-cycle instruction sequencer and its external ALU:
// opcode map, sequencer state encoding, register-file write-source codes and decode helpers.
package alu_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } seq_state_e;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_ADDI = 6'd2;
    localparam logic [5:0] OP_SUBI = 6'd3;
    localparam logic [5:0] OP_LW   = 6'd4;
    localparam logic [5:0] OP_SW   = 6'd5;
    localparam logic [5:0] OP_AND  = 6'd6;
    localparam logic [5:0] OP_OR   = 6'd7;
    localparam logic [5:0] OP_ANDI = 6'd8;
    localparam logic [5:0] OP_ORI  = 6'd9;
    localparam logic [5:0] OP_XOR  = 6'd10;
    localparam logic [5:0] OP_SLT  = 6'd11;
    localparam logic [5:0] OP_NOP  = 6'd12;
    localparam logic [5:0] OP_NOP2 = 6'd13;
    localparam logic [5:0] OP_BEQ  = 6'd14;
    localparam logic [5:0] OP_BNE  = 6'd15;
    localparam logic [5:0] OP_BLT  = 6'd16;
    localparam logic [5:0] OP_BGE  = 6'd17;
    localparam logic [5:0] OP_BLE  = 6'd18;
    localparam logic [5:0] OP_BGT  = 6'd19;
    localparam logic [5:0] OP_J    = 6'd20;
    localparam logic [5:0] OP_JR   = 6'd21;
    localparam logic [5:0] OP_JAL  = 6'd22;
    localparam logic [5:0] OP_SLL  = 6'd23;
    localparam logic [5:0] OP_LUI  = 6'd24;
    localparam logic [5:0] OP_HALT = 6'd63;

    localparam logic [1:0] WSEL_ALU  = 2'd0;
    localparam logic [1:0] WSEL_MEM  = 2'd1;
    localparam logic [1:0] WSEL_LINK = 2'd2;

    function automatic logic op_uses_imm(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_SUBI, OP_LW, OP_SW, OP_ANDI, OP_ORI, OP_LUI: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_rtype(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Every opcode in 0..11 writes back, so sw also returns its ALU result to rt.
    function automatic logic op_writes_rf(input logic [5:0] op);
        return (op <= OP_SLT) || (op == OP_JAL) || (op == OP_SLL) || (op == OP_LUI);
    endfunction

    function automatic logic op_is_branch(input logic [5:0] op);
        return (op >= OP_BEQ) && (op <= OP_BGT);
    endfunction

    function automatic logic op_is_illegal(input logic [5:0] op);
        return (op > OP_LUI) && (op < OP_HALT);
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Memory, ALU and register-file connections of the sequencer; master is the sequencer side.
interface alu_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        alu_src_imm;
    logic [31:0] alu_c;
    logic        alu_zero;
    logic [31:0] rs_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [1:0]  rf_wsel;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic        dmem_ack;

    modport master (
        output imem_req, imem_addr, ir, alu_src_imm, rf_we, rf_waddr, rf_wsel,
               dmem_req, dmem_we, dmem_addr,
        input  imem_valid, imem_rdata, alu_c, alu_zero, rs_data, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, ir, alu_src_imm, rf_we, rf_waddr, rf_wsel,
               dmem_req, dmem_we, dmem_addr,
        output imem_valid, imem_rdata, alu_c, alu_zero, rs_data, dmem_ack
    );
endinterface

// File: rtl/alu_sequencer_seq_timeout.sv
// Wait-cycle counter for fetch and data handshakes; expired flags the last permitted waiting cycle.
module seq_timeout #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expired
);
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] cnt_r;

    // Count waiting cycles, saturating on the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (count && (cnt_r != LAST)) begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign expired = count && (cnt_r == LAST);

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer driving an external ALU,
// register file and separate instruction/data memories.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    alu_sequencer_if.master       bus,
    output logic [31:0]           pc,
    output logic                  busy,
    output logic                  halted,
    output logic                  err,
    output logic [31:0]           instret
);
    seq_state_e  state_r, state_s;
    logic [31:0] pc_r, ir_r, instret_r, pc_next_s;
    logic        err_r, halted_r, busy_r, alu_src_imm_r;
    logic        imem_req_r, dmem_req_r, dmem_we_r, rf_we_r;
    logic [4:0]  rf_waddr_r, waddr_s;
    logic [1:0]  rf_wsel_r, wsel_s;
    logic [5:0]  op_s;
    logic        wait_s, clear_s, timeout_s, err_set_s, launch_s;

    assign op_s     = ir_r[31:26];
    assign wait_s   = ((state_r == ST_FETCH) && !bus.imem_valid) || ((state_r == ST_MEM) && !bus.dmem_ack);
    assign clear_s  = (state_r != ST_FETCH) && (state_r != ST_MEM);
    assign launch_s = ((state_r == ST_IDLE) || (state_r == ST_HALT)) && start;

    seq_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear_s),
        .count   (wait_s),
        .expired (timeout_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state selection and error detection.
    always_comb begin
        state_s   = state_r;
        err_set_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_HALT: begin
                if (start) state_s = ST_FETCH;
                else       state_s = state_r;
            end
            ST_FETCH: begin
                if (bus.imem_valid) begin
                    state_s = ST_DECODE;
                end else if (timeout_s) begin
                    state_s   = ST_HALT;
                    err_set_s = 1'b1;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DECODE: state_s = ST_EXEC;
            ST_EXEC: begin
                if ((op_s == OP_LW) || (op_s == OP_SW)) state_s = ST_MEM;
                else                                     state_s = ST_WB;
            end
            ST_MEM: begin
                if (bus.dmem_ack) begin
                    state_s = ST_WB;
                end else if (timeout_s) begin
                    state_s   = ST_HALT;
                    err_set_s = 1'b1;
                end else begin
                    state_s = ST_MEM;
                end
            end
            ST_WB: begin
                if (op_s == OP_HALT) begin
                    state_s = ST_HALT;
                end else if (op_is_illegal(op_s)) begin
                    state_s   = ST_HALT;
                    err_set_s = 1'b1;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Program-counter successor; illegal opcodes leave pc pointing at the offender.
    always_comb begin
        pc_next_s = pc_r + 32'd1;
        if (op_is_branch(op_s)) begin
            if (bus.alu_zero) pc_next_s = pc_r + 32'd1 + sext16(ir_r[15:0]);
            else              pc_next_s = pc_r + 32'd1;
        end else if ((op_s == OP_J) || (op_s == OP_JAL)) begin
            pc_next_s = {6'b0, ir_r[25:0]};
        end else if (op_s == OP_JR) begin
            pc_next_s = bus.rs_data;
        end else if (op_is_illegal(op_s)) begin
            pc_next_s = pc_r;
        end else begin
            pc_next_s = pc_r + 32'd1;
        end
    end

    // Register-file destination and write source.
    always_comb begin
        waddr_s = ir_r[20:16];
        wsel_s  = WSEL_ALU;
        if (op_s == OP_JAL) begin
            waddr_s = 5'd31;
            wsel_s  = WSEL_LINK;
        end else if (op_s == OP_LW) begin
            waddr_s = ir_r[20:16];
            wsel_s  = WSEL_MEM;
        end else if (op_is_rtype(op_s)) begin
            waddr_s = ir_r[15:11];
            wsel_s  = WSEL_ALU;
        end else begin
            waddr_s = ir_r[20:16];
            wsel_s  = WSEL_ALU;
        end
    end

    // Architectural state: pc, instruction register, retire counter, error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            ir_r          <= 32'h0;
            instret_r     <= 32'h0;
            err_r         <= 1'b0;
            alu_src_imm_r <= 1'b0;
        end else begin
            if (launch_s) begin
                pc_r      <= RESET_PC;
                instret_r <= 32'h0;
                err_r     <= 1'b0;
            end
            if ((state_r == ST_FETCH) && bus.imem_valid) ir_r <= bus.imem_rdata;
            if (state_r == ST_DECODE) alu_src_imm_r <= op_uses_imm(op_s);
            if (state_r == ST_WB) begin
                pc_r <= pc_next_s;
                if (instret_r != 32'hFFFF_FFFF) instret_r <= instret_r + 32'd1;
            end
            if (err_set_s) err_r <= 1'b1;
        end
    end

    // Handshake and status outputs registered from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r     <= 1'b0;
            halted_r   <= 1'b0;
            imem_req_r <= 1'b0;
            dmem_req_r <= 1'b0;
            dmem_we_r  <= 1'b0;
            rf_we_r    <= 1'b0;
            rf_waddr_r <= 5'd0;
            rf_wsel_r  <= WSEL_ALU;
        end else begin
            busy_r     <= (state_s != ST_IDLE) && (state_s != ST_HALT);
            halted_r   <= (state_s == ST_HALT);
            imem_req_r <= (state_s == ST_FETCH);
            dmem_req_r <= (state_s == ST_MEM);
            dmem_we_r  <= (state_s == ST_MEM) && (op_s == OP_SW);
            rf_we_r    <= (state_s == ST_WB) && op_writes_rf(op_s);
            if (state_s == ST_WB) begin
                rf_waddr_r <= waddr_s;
                rf_wsel_r  <= wsel_s;
            end
        end
    end

    assign bus.imem_req    = imem_req_r;
    assign bus.imem_addr   = pc_r;
    assign bus.ir          = ir_r;
    assign bus.alu_src_imm = alu_src_imm_r;
    assign bus.rf_we       = rf_we_r;
    assign bus.rf_waddr    = rf_waddr_r;
    assign bus.rf_wsel     = rf_wsel_r;
    assign bus.dmem_req    = dmem_req_r;
    assign bus.dmem_we     = dmem_we_r;
    assign bus.dmem_addr   = bus.alu_c;
    assign pc              = pc_r;
    assign busy            = busy_r;
    assign halted          = halted_r;
    assign err             = err_r;
    assign instret         = instret_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: expected writeback/pc/latency per instruction are queued
// when the instruction is presented and popped once the sequencer retires it.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [1:0]  ws;
        logic        chk_pc;
        logic [31:0] pc;
        logic        imm;
        logic [7:0]  cyc;
        logic [7:0]  dreq;
        logic        dwe;
    } exp_t;

    logic        clk, rst, start;
    logic [31:0] pc, instret;
    logic        busy, halted, err;
    int          checks, errors;
    logic [31:0] pc_model;
    logic [31:0] instret_model;
    exp_t        sb_q[$];

    alu_sequencer_if bus();

    alu_sequencer #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bus     (bus),
        .pc      (pc),
        .busy    (busy),
        .halted  (halted),
        .err     (err),
        .instret (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'h000};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    function automatic exp_t mk(input logic we, input logic [4:0] wa, input logic [1:0] ws, input logic chk_pc,
                                input logic [31:0] npc, input logic imm, input logic [7:0] cyc,
                                input logic [7:0] dreq, input logic dwe);
        exp_t e;
        e.we = we; e.wa = wa; e.ws = ws; e.chk_pc = chk_pc; e.pc = npc;
        e.imm = imm; e.cyc = cyc; e.dreq = dreq; e.dwe = dwe;
        return e;
    endfunction

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pc_model      = 32'h0000_0000;
        instret_model = 32'h0;
        checks++;
        if (busy !== 1'b1 || bus.imem_req !== 1'b1 || pc !== 32'h0000_0000) begin
            errors++;
            $display("FAIL start: busy=%b imem_req=%b pc=%h, required 1 1 00000000", busy, bus.imem_req, pc);
        end
        checks++;
        if (instret !== 32'h0 || err !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL start_clear: instret=%0d err=%b halted=%b, required 0 0 0", instret, err, halted);
        end
    endtask

    // Runs one instruction from its first FETCH cycle to the first cycle after WB.
    task automatic do_instr(input string nm, input logic [31:0] instr, input int ilat, input int dlat,
                            input logic zero, input logic [31:0] rsd, input logic st, input exp_t e);
        exp_t x;
        int   cycles, fcnt, dcnt, we_cnt, we_cyc, dreq_cnt;
        logic fetched, dwe_seen, imm_seen;
        logic [4:0] wa;
        logic [1:0] ws;
        sb_q.push_back(e);
        cycles = 0; fcnt = 0; dcnt = 0; we_cnt = 0; we_cyc = 0; dreq_cnt = 0;
        fetched = 1'b0; dwe_seen = 1'b0; imm_seen = 1'b0; wa = 5'd0; ws = 2'd0;
        bus.alu_zero = zero; bus.rs_data = rsd; bus.alu_c = 32'h0000_0040; start = st;
        checks++;
        if (bus.imem_addr !== pc_model) begin
            errors++;
            $display("FAIL %s imem_addr: got %h, required %h", nm, bus.imem_addr, pc_model);
        end
        while (cycles < 100 && !(fetched && (bus.imem_req || !busy))) begin
            cycles++;
            bus.imem_valid = 1'b0;
            bus.dmem_ack   = 1'b0;
            if (bus.imem_req) begin
                if (fcnt == ilat) begin
                    bus.imem_valid = 1'b1;
                    bus.imem_rdata = instr;
                    fetched = 1'b1;
                end
                fcnt++;
            end
            if (bus.dmem_req) begin
                dreq_cnt++;
                if (bus.dmem_we) dwe_seen = 1'b1;
                checks++;
                if (bus.dmem_addr !== 32'h0000_0040) begin
                    errors++;
                    $display("FAIL %s dmem_addr: got %h, required 00000040", nm, bus.dmem_addr);
                end
                if (dcnt == dlat) bus.dmem_ack = 1'b1;
                dcnt++;
            end
            if (cycles == ilat + 3) imm_seen = bus.alu_src_imm;
            if (bus.rf_we) begin
                we_cnt++;
                we_cyc = cycles;
                wa = bus.rf_waddr;
                ws = bus.rf_wsel;
            end
            @(negedge clk);
        end
        bus.imem_valid = 1'b0;
        bus.dmem_ack   = 1'b0;
        start = 1'b0;
        x = sb_q.pop_front();
        checks++;
        if (cycles !== int'(x.cyc)) begin
            errors++;
            $display("FAIL %s cycles: got %0d, required %0d", nm, cycles, x.cyc);
        end
        checks++;
        if (we_cnt !== (x.we ? 1 : 0)) begin
            errors++;
            $display("FAIL %s rf_we_pulses: got %0d, required %0d", nm, we_cnt, x.we);
        end
        if (x.we) begin
            checks++;
            if (wa !== x.wa || ws !== x.ws || we_cyc !== cycles) begin
                errors++;
                $display("FAIL %s rf_write: waddr=%0d wsel=%0d cycle=%0d, required %0d %0d %0d",
                         nm, wa, ws, we_cyc, x.wa, x.ws, cycles);
            end
        end
        if (x.chk_pc) begin
            checks++;
            if (pc !== x.pc) begin
                errors++;
                $display("FAIL %s pc: got %h, required %h", nm, pc, x.pc);
            end
        end
        checks++;
        if (imm_seen !== x.imm) begin
            errors++;
            $display("FAIL %s alu_src_imm: got %b, required %b", nm, imm_seen, x.imm);
        end
        checks++;
        if (dreq_cnt !== int'(x.dreq) || dwe_seen !== x.dwe) begin
            errors++;
            $display("FAIL %s dmem: req_cycles=%0d we=%b, required %0d %b", nm, dreq_cnt, dwe_seen, x.dreq, x.dwe);
        end
        instret_model = instret_model + 32'd1;
        checks++;
        if (instret !== instret_model) begin
            errors++;
            $display("FAIL %s instret: got %0d, required %0d", nm, instret, instret_model);
        end
        pc_model = x.pc;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        bus.imem_valid = 1'b0; bus.imem_rdata = 32'h0; bus.dmem_ack = 1'b0;
        bus.alu_c = 32'h0; bus.alu_zero = 1'b0; bus.rs_data = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (pc !== 32'h0 || instret !== 32'h0 || bus.ir !== 32'h0 || busy !== 1'b0 || halted !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pc=%h instret=%0d ir=%h busy=%b halted=%b err=%b", pc, instret, bus.ir, busy, halted, err);
        end
        checks++;
        if (bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0 || bus.rf_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: imem_req=%b dmem_req=%b dmem_we=%b rf_we=%b, required 0", bus.imem_req, bus.dmem_req, bus.dmem_we, bus.rf_we);
        end
        rst = 1'b0;
    endtask

    task automatic test_program();
        do_start();
        do_instr("add",  enc_r(OP_ADD, 5'd1, 5'd2, 5'd3), 0, 0, 1'b0, 32'h0, 1'b0, mk(1'b1, 5'd3, WSEL_ALU, 1'b1, 32'd1, 1'b0, 8'd4, 8'd0, 1'b0));
        do_instr("addi", enc_i(OP_ADDI, 5'd1, 5'd7, 16'h0005), 2, 0, 1'b0, 32'h0, 1'b1, mk(1'b1, 5'd7, WSEL_ALU, 1'b1, 32'd2, 1'b1, 8'd6, 8'd0, 1'b0));
        do_instr("j10",  enc_j(OP_J, 26'd10), 0, 0, 1'b0, 32'h0, 1'b0, mk(1'b0, 5'd0, WSEL_ALU, 1'b1, 32'd10, 1'b0, 8'd4, 8'd0, 1'b0));
        do_instr("beq_t", enc_i(OP_BEQ, 5'd1, 5'd2, 16'hFFFE), 0, 0, 1'b1, 32'h0, 1'b0, mk(1'b0, 5'd0, WSEL_ALU, 1'b1, 32'd9, 1'b0, 8'd4, 8'd0, 1'b0));
        do_instr("j10b", enc_j(OP_J, 26'd10), 0, 0, 1'b0, 32'h0, 1'b0, mk(1'b0, 5'd0, WSEL_ALU, 1'b1, 32'd10, 1'b0, 8'd4, 8'd0, 1'b0));
        do_instr("beq_n", enc_i(OP_BEQ, 5'd1, 5'd2, 16'hFFFE), 0, 0, 1'b0, 32'h0, 1'b0, mk(1'b0, 5'd0, WSEL_ALU, 1'b1, 32'd11, 1'b0, 8'd4, 8'd0, 1'b0));
        do_instr("lw",   enc_i(OP_LW, 5'd1, 5'd5, 16'h0010), 0, 3, 1'b0, 32'h0, 1'b0, mk(1'b1, 5'd5, WSEL_MEM, 1'b1, 32'd12, 1'b1, 8'd8, 8'd4, 1'b0));
        do_instr("sw",   enc_i(OP_SW, 5'd1, 5'd6, 16'h0010), 0, 0, 1'b0, 32'h0, 1'b0, mk(1'b1, 5'd6, WSEL_ALU, 1'b1, 32'd13, 1'b1, 8'd5, 8'd1, 1'b1));
        do_instr("nop",  enc_r(OP_NOP, 5'd1, 5'd2, 5'd3), 0, 0, 1'b0, 32'h0, 1'b0, mk(1'b0, 5'd0, WSEL_ALU, 1'b1, 32'd14, 1'b0, 8'd4, 8'd0, 1'b0));
        do_instr("sll",  enc_r(OP_SLL, 5'd1, 5'd4, 5'd9), 0, 0, 1'b0, 32'h0, 1'b0, mk(1'b1, 5'd9, WSEL_ALU, 1'b1, 32'd15, 1'b0, 8'd4, 8'd0, 1'b0));
        do_instr("lui",  enc_i(OP_LUI, 5'd0, 5'd4, 16'h1234), 0, 0, 1'b0, 32'h0, 1'b0, mk(1'b1, 5'd4, WSEL_ALU, 1'b1, 32'd16, 1'b1, 8'd4, 8'd0, 1'b0));
        do_instr("jr",   enc_r(OP_JR, 5'd8, 5'd0, 5'd0), 0, 0, 1'b0, 32'hFFFF_FFFF, 1'b0, mk(1'b0, 5'd0, WSEL_ALU, 1'b1, 32'hFFFF_FFFF, 1'b0, 8'd4, 8'd0, 1'b0));
        do_instr("wrap", enc_r(OP_NOP2, 5'd0, 5'd0, 5'd0), 0, 0, 1'b0, 32'h0, 1'b0, mk(1'b0, 5'd0, WSEL_ALU, 1'b1, 32'h0, 1'b0, 8'd4, 8'd0, 1'b0));
        do_instr("j5",   enc_j(OP_J, 26'd5), 0, 0, 1'b0, 32'h0, 1'b0, mk(1'b0, 5'd0, WSEL_ALU, 1'b1, 32'd5, 1'b0, 8'd4, 8'd0, 1'b0));
        do_instr("jal",  enc_j(OP_JAL, 26'h100), 0, 0, 1'b0, 32'h0, 1'b0, mk(1'b1, 5'd31, WSEL_LINK, 1'b1, 32'h100, 1'b0, 8'd4, 8'd0, 1'b0));
        do_instr("halt", enc_j(OP_HALT, 26'h0), 0, 0, 1'b0, 32'h0, 1'b0, mk(1'b0, 5'd0, WSEL_ALU, 1'b0, 32'h101, 1'b0, 8'd4, 8'd0, 1'b0));
        checks++;
        if (halted !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL halt_state: halted=%b err=%b busy=%b, required 1 0 0", halted, err, busy);
        end
    endtask

    task automatic test_illegal();
        do_start();
        do_instr("illegal", enc_j(6'd30, 26'h0), 0, 0, 1'b0, 32'h0, 1'b0, mk(1'b0, 5'd0, WSEL_ALU, 1'b1, 32'h0, 1'b0, 8'd4, 8'd0, 1'b0));
        checks++;
        if (halted !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL illegal_state: halted=%b err=%b busy=%b, required 1 1 0", halted, err, busy);
        end
    endtask

    task automatic test_timeout();
        int n, guard;
        do_start();
        n = 0; guard = 0;
        while (!halted && guard < 100) begin
            if (bus.imem_req) n++;
            guard++;
            @(negedge clk);
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d fetch cycles, required 16", n);
        end
        checks++;
        if (halted !== 1'b1 || err !== 1'b1 || busy !== 1'b0 || instret !== 32'h0) begin
            errors++;
            $display("FAIL timeout_state: halted=%b err=%b busy=%b instret=%0d, required 1 1 0 0", halted, err, busy, instret);
        end
    endtask

    task automatic test_reset_mid_mem();
        do_start();
        do_instr("pre_nop", enc_r(OP_NOP, 5'd0, 5'd0, 5'd0), 0, 0, 1'b0, 32'h0, 1'b0, mk(1'b0, 5'd0, WSEL_ALU, 1'b1, 32'd1, 1'b0, 8'd4, 8'd0, 1'b0));
        bus.imem_valid = 1'b1;
        bus.imem_rdata = enc_i(OP_LW, 5'd1, 5'd5, 16'h0004);
        @(negedge clk);
        bus.imem_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_mem_req: got %b, required 1", bus.dmem_req);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.dmem_req !== 1'b0 || busy !== 1'b0 || pc !== 32'h0 || instret !== 32'h0 || bus.ir !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: dmem_req=%b busy=%b pc=%h instret=%0d ir=%h, required 0 0 0 0 0",
                     bus.dmem_req, busy, pc, instret, bus.ir);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.imem_valid = 1'b1;
        bus.dmem_ack   = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0 || bus.ir !== 32'h0) begin
            errors++;
            $display("FAIL reset_release: busy=%b imem_req=%b dmem_req=%b ir=%h, required idle", busy, bus.imem_req, bus.dmem_req, bus.ir);
        end
        bus.imem_valid = 1'b0;
        bus.dmem_ack   = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pc_model = 32'h0;
        instret_model = 32'h0;
        test_reset();
        test_program();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
